// File: rtl/match_event_monitor.sv
// Match event monitor: saturating total match count plus a windowed match counter
// that raises a sticky alarm when the in-window count reaches a threshold.
module match_event_monitor #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             F,
    input  logic             enable,
    input  logic [WIN_W-1:0] window_len,
    input  logic [CNT_W-1:0] threshold,
    input  logic             ack,
    input  logic             clr_total,
    output logic [CNT_W-1:0] total_count,
    output logic [CNT_W-1:0] win_count,
    output logic             alarm,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWindow = 2'd1,
        StAlarm  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [WIN_W-1:0] WinOne = WIN_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] timer_q, timer_d;

    logic             trig;
    logic [CNT_W-1:0] thr_eff;
    logic [CNT_W:0]   win_sum;
    logic [CNT_W-1:0] win_inc;
    logic             reach;

    assign trig    = enable & F;
    assign thr_eff = (threshold == '0) ? CntOne : threshold;
    // One extra bit so the threshold compare and saturation see the carry.
    assign win_sum = {1'b0, win_q} + {{CNT_W{1'b0}}, F};
    assign win_inc = win_sum[CNT_W] ? CntMax : win_sum[CNT_W-1:0];
    assign reach   = win_sum >= {1'b0, thr_eff};

    always_comb begin
        total_d = total_q;
        if (clr_total) begin
            total_d = '0;
        end else if (trig && (total_q != CntMax)) begin
            total_d = total_q + CntOne;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        timer_d = timer_q;
        case (state_q)
            StIdle: begin
                win_d = '0;
                if (trig) begin
                    if (thr_eff == CntOne) begin
                        state_d = StAlarm;
                        win_d   = CntOne;
                    end else if (window_len > WinOne) begin
                        state_d = StWindow;
                        win_d   = CntOne;
                        timer_d = window_len - WinOne;
                    end
                end
            end
            StWindow: begin
                if (!enable) begin
                    state_d = StIdle;
                    win_d   = '0;
                end else if (reach) begin
                    state_d = StAlarm;
                    win_d   = win_inc;
                end else if (timer_q == WinOne) begin
                    // Final-cycle match below threshold is dropped with the window.
                    state_d = StIdle;
                    win_d   = '0;
                end else begin
                    timer_d = timer_q - WinOne;
                    win_d   = win_inc;
                end
            end
            StAlarm: begin
                if (ack) begin
                    state_d = StIdle;
                    win_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                win_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            total_q <= '0;
            win_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            win_q   <= win_d;
            timer_q <= timer_d;
        end
    end

    assign total_count = total_q;
    assign win_count   = win_q;
    assign alarm       = (state_q == StAlarm);
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_match_event_monitor.sv
// Self-checking bench for match_event_monitor: a behavioural model pushes expected
// outputs to a scoreboard each cycle; tests pop and compare, plus fixed-value checks.
module tb_match_event_monitor;

    logic       clock = 1'b0;
    logic       reset;
    logic       F;
    logic       enable;
    logic [7:0] window_len;
    logic [7:0] threshold;
    logic       ack;
    logic       clr_total;
    logic [7:0] total_count;
    logic [7:0] win_count;
    logic       alarm;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [17:0] sbq[$];
    logic [17:0] exp_v;
    int m_st, m_tot, m_win, m_tim;

    always #5 clock = ~clock;

    match_event_monitor #(
        .CNT_W(8),
        .WIN_W(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .F          (F),
        .enable     (enable),
        .window_len (window_len),
        .threshold  (threshold),
        .ack        (ack),
        .clr_total  (clr_total),
        .total_count(total_count),
        .win_count  (win_count),
        .alarm      (alarm),
        .busy       (busy)
    );

    function automatic void model_reset();
        m_st  = 0;
        m_tot = 0;
        m_win = 0;
        m_tim = 0;
        sbq.delete();
    endfunction

    // Behavioural reference: state 0=idle, 1=window, 2=alarm.
    function automatic void model_step();
        int thr;
        bit trig;
        thr  = (threshold == 8'd0) ? 1 : int'(threshold);
        trig = enable && F;
        if (clr_total) m_tot = 0;
        else if (trig && m_tot < 255) m_tot++;
        case (m_st)
            0: begin
                m_win = 0;
                if (trig) begin
                    if (thr == 1) begin
                        m_st = 2; m_win = 1;
                    end else if (window_len > 1) begin
                        m_st = 1; m_win = 1; m_tim = int'(window_len) - 1;
                    end
                end
            end
            1: begin
                if (!enable) begin
                    m_st = 0; m_win = 0;
                end else if (m_win + int'(F) >= thr) begin
                    m_st = 2; m_win = m_win + int'(F);
                end else if (m_tim == 1) begin
                    m_st = 0; m_win = 0;
                end else begin
                    m_tim--; m_win = m_win + int'(F);
                end
            end
            default: if (ack) begin
                m_st = 0; m_win = 0;
            end
        endcase
        sbq.push_back({8'(m_tot), 8'(m_win), m_st == 2, m_st != 0});
    endfunction

    task automatic cyc(input logic f, input logic en, input logic a, input logic clr);
        F = f; enable = en; ack = a; clr_total = clr;
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            F = i[0]; enable = ~i[0];
            @(posedge clock);
            #1;
            n_cmp++;
            if ({total_count, win_count, alarm, busy} !== 18'd0) begin
                n_err++;
                $display("FAIL reset_hold: got %h want %h", {total_count, win_count, alarm, busy}, 18'd0);
            end
        end
        F = 1'b0; enable = 1'b0;
        reset = 1'b1;
        model_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        exp_v = sbq.pop_front();
        n_cmp++;
        if ({total_count, win_count, alarm, busy} !== exp_v || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", {total_count, win_count, alarm, busy}, exp_v);
        end
    endtask

    task automatic test_basic();
        window_len = 8'd10; threshold = 8'd3;
        for (int c = -1; c <= 10; c++) begin
            cyc(c == 0 || c == 3 || c == 6, 1'b1, c == 9, c == -1);
            exp_v = sbq.pop_front();
            n_cmp++;
            if ({total_count, win_count, alarm, busy} !== exp_v) begin
                n_err++;
                $display("FAIL basic_sb c%0d: got %h want %h", c, {total_count, win_count, alarm, busy}, exp_v);
            end
            if (c == 0 || c == 6 || c == 9) begin
                exp_v = (c == 0) ? {8'd1, 8'd1, 1'b0, 1'b1} :
                        (c == 6) ? {8'd3, 8'd3, 1'b1, 1'b1} : {8'd3, 8'd0, 1'b0, 1'b0};
                n_cmp++;
                if ({total_count, win_count, alarm, busy} !== exp_v) begin
                    n_err++;
                    $display("FAIL basic_fixed c%0d: got %h want %h", c, {total_count, win_count, alarm, busy}, exp_v);
                end
            end
        end
    endtask

    task automatic test_expiry();
        window_len = 8'd4; threshold = 8'd3;
        for (int c = -1; c <= 4; c++) begin
            cyc(c == 0 || c == 3, 1'b1, 1'b0, c == -1);
            exp_v = sbq.pop_front();
            n_cmp++;
            if ({total_count, win_count, alarm, busy} !== exp_v) begin
                n_err++;
                $display("FAIL expiry_sb c%0d: got %h want %h", c, {total_count, win_count, alarm, busy}, exp_v);
            end
            if (c == 3) begin
                n_cmp++;
                if ({total_count, win_count, alarm, busy} !== {8'd2, 8'd0, 1'b0, 1'b0}) begin
                    n_err++;
                    $display("FAIL expiry_end: got %h want %h", {total_count, win_count, alarm, busy},
                             {8'd2, 8'd0, 1'b0, 1'b0});
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [17:0] fixed [4];
        fixed[0] = {8'd1, 8'd1, 1'b1, 1'b1};
        fixed[1] = {8'd2, 8'd0, 1'b0, 1'b0};
        fixed[2] = {8'd3, 8'd1, 1'b1, 1'b1};
        fixed[3] = {8'd3, 8'd0, 1'b0, 1'b0};
        window_len = 8'd10;
        for (int c = -1; c <= 3; c++) begin
            threshold = (c >= 2) ? 8'd0 : 8'd1;
            cyc(c >= 0 && c <= 2, 1'b1, c == 1 || c == 3, c == -1);
            exp_v = sbq.pop_front();
            n_cmp++;
            if ({total_count, win_count, alarm, busy} !== exp_v) begin
                n_err++;
                $display("FAIL simul_sb c%0d: got %h want %h", c, {total_count, win_count, alarm, busy}, exp_v);
            end
            if (c >= 0) begin
                n_cmp++;
                if ({total_count, win_count, alarm, busy} !== fixed[c]) begin
                    n_err++;
                    $display("FAIL simul_fixed c%0d: got %h want %h", c, {total_count, win_count, alarm, busy},
                             fixed[c]);
                end
            end
        end
    endtask

    task automatic test_enable_clear();
        window_len = 8'd10; threshold = 8'd5;
        for (int c = -1; c <= 7; c++) begin
            cyc(c >= 0 && c != 6, !(c >= 2 && c <= 4) && c != 6, 1'b0, c == -1 || c == 5);
            exp_v = sbq.pop_front();
            n_cmp++;
            if ({total_count, win_count, alarm, busy} !== exp_v) begin
                n_err++;
                $display("FAIL enclr_sb c%0d: got %h want %h", c, {total_count, win_count, alarm, busy}, exp_v);
            end
            if (c == 2 || c == 4 || c == 5) begin
                exp_v = (c == 5) ? {8'd0, 8'd1, 1'b0, 1'b1} : {8'd2, 8'd0, 1'b0, 1'b0};
                n_cmp++;
                if ({total_count, win_count, alarm, busy} !== exp_v) begin
                    n_err++;
                    $display("FAIL enclr_fixed c%0d: got %h want %h", c, {total_count, win_count, alarm, busy}, exp_v);
                end
            end
        end
        // Asynchronous reset in the middle of an open window, between clock edges.
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({total_count, win_count, alarm, busy} !== 18'd0) begin
            n_err++;
            $display("FAIL async_reset: got %h want %h", {total_count, win_count, alarm, busy}, 18'd0);
        end
        #1 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_saturation();
        window_len = 8'd255; threshold = 8'd255;
        for (int c = -1; c <= 300; c++) begin
            cyc(c >= 0 && c < 300, 1'b1, c == 300, c == -1);
            exp_v = sbq.pop_front();
            n_cmp++;
            if ({total_count, win_count, alarm, busy} !== exp_v) begin
                n_err++;
                $display("FAIL sat_sb c%0d: got %h want %h", c, {total_count, win_count, alarm, busy}, exp_v);
            end
            if (c == 253 || c == 254 || c == 299) begin
                exp_v = (c == 253) ? {8'd254, 8'd254, 1'b0, 1'b1} :
                        (c == 254) ? {8'd255, 8'd255, 1'b1, 1'b1} : {8'd255, 8'd255, 1'b1, 1'b1};
                n_cmp++;
                if ({total_count, win_count, alarm, busy} !== exp_v) begin
                    n_err++;
                    $display("FAIL sat_fixed c%0d: got %h want %h", c, {total_count, win_count, alarm, busy}, exp_v);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0; F = 1'b0; enable = 1'b0; ack = 1'b0; clr_total = 1'b0;
        window_len = 8'd0; threshold = 8'd0;
        model_reset();
        test_reset();
        test_basic();
        test_expiry();
        test_simultaneous();
        test_enable_clear();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
